// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencing controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_ex3.sv
// Single-digit BCD to Excess-3 converter; non-BCD digits map to 0 and raise invalid_o.
module bcd_digit_ex3
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] ex3_o,
    output logic       invalid_o
);

    // 9 + 3 = 4'hC fits in a nibble, so no carry handling is needed
    always_comb begin
        invalid_o = (digit_i > BCD_MAX);
        ex3_o     = invalid_o ? 4'h0 : (digit_i + EX3_OFFSET);
    end

endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// Converts a packed multi-digit BCD word to Excess-3, one digit per cycle, LSD first,
// through a single shared digit converter. Valid/ready handshakes on both sides.
module bcd_ex3_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_ex3,
    output logic                  out_err,
    output logic                  busy
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    word_q,  word_d;
    logic [W-1:0]    res_q,   res_d;
    logic [IdxW-1:0] idx_q,   idx_d;
    logic            err_q,   err_d;
    // Set once the last digit is written; CONV spends one more cycle before DONE
    logic            last_q,  last_d;

    logic [3:0] conv_digit;
    logic [3:0] conv_ex3;
    logic       conv_inv;

    assign conv_digit = word_q[{idx_q, 2'b00} +: 4];

    bcd_digit_ex3 u_digit (
        .digit_i   (conv_digit),
        .ex3_o     (conv_ex3),
        .invalid_o (conv_inv)
    );

    // Next-state: accept in IDLE, walk digits in CONV, hold result in DONE
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        res_d   = res_q;
        idx_d   = idx_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_bcd;
                    res_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (last_q) begin
                    state_d = DONE;
                end else begin
                    res_d[{idx_q, 2'b00} +: 4] = conv_ex3;
                    err_d = err_q | conv_inv;
                    if (idx_q == LastIdx) begin
                        last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_ex3   = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Directed bench for bcd_ex3_seq_ctrl (DIGITS=4 and DIGITS=1 builds) with a result scoreboard.
module tb_bcd_ex3_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bcd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ex3;
    logic        out_err;
    logic        busy;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  in_bcd1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [3:0]  out_ex31;
    logic        out_err1;
    logic        busy1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] ex3;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_ex3_seq_ctrl #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ex3   (out_ex3),
        .out_err   (out_err),
        .busy      (busy)
    );

    bcd_ex3_seq_ctrl #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_bcd    (in_bcd1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_ex3   (out_ex31),
        .out_err   (out_err1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a word, check latency, optionally stall the sink, then hand off
    task automatic run_word(input string tag, input logic [15:0] word, input logic [15:0] exp_ex3,
                            input logic exp_err, input int hold);
        int n;
        exp_t e;
        logic [15:0] held;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = word;
        step();
        in_valid = 1'b0;
        in_bcd   = ~word;  // source changes during CONV must not matter
        sb.push_back('{ex3: exp_ex3, err: exp_err});
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        held = out_ex3;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_bcd   = 16'h0000;
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ex3"}, 32'(out_ex3), 32'(held));
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ex3"}, 32'(out_ex3), 32'(e.ex3));
            check({tag, "_err"}, 32'(out_err), 32'(e.err));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_ex3", 32'(out_ex3), 32'd0);
        rst_n = 1'b1;
        step();

        run_word("w1234", 16'h1234, 16'h4567, 1'b0, 0);
        run_word("w0909", 16'h0909, 16'h3C3C, 1'b0, 0);
        run_word("w12A4", 16'h12A4, 16'h4507, 1'b1, 0);
        run_word("w0000", 16'h0000, 16'h3333, 1'b0, 0);
        run_word("w5678", 16'h5678, 16'h89AB, 1'b0, 5);

        // Reset mid-CONV: word dropped, outputs return to reset values at once
        in_valid = 1'b1;
        in_bcd   = 16'h9999;
        step();
        in_valid = 1'b0;
        in_bcd   = 16'h1111;
        step();
        in_bcd   = 16'h2222;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_ex3", 32'(out_ex3), 32'd0);
        check("mid_rst_out_err", 32'(out_err), 32'd0);
        step();
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("mid_rst_no_output", 32'(pulses), 32'd0);
        run_word("w0001", 16'h0001, 16'h3334, 1'b0, 0);

        // DIGITS=1 build
        check("d1_in_ready", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        in_bcd1   = 4'h9;
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        check("d1_latency", 32'(n), 32'd2);
        check("d1_ex3", 32'(out_ex31), 32'hC);
        check("d1_err", 32'(out_err1), 32'd0);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("d1_post_inrdy", 32'(in_ready1), 32'd1);

        in_valid1 = 1'b1;
        in_bcd1   = 4'hB;
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        check("d1b_latency", 32'(n), 32'd2);
        check("d1b_ex3", 32'(out_ex31), 32'h0);
        check("d1b_err", 32'(out_err1), 32'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
